// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must be able to hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell; WIDTH+1-bit signed
// result held in Diff and announced by a one-cycle valid strobe.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             enable,
    output logic [WIDTH:0]   Diff,
    output logic             busy,
    output logic             valid
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // Difference bits enter from the MSB side so bit 0 lands last.
                res_d    = WIDTH'({cell_d, res_q} >> 1);
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                diff_d  = {borrow_q, res_q};
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign Diff  = diff_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random
// operands checked against a plain-arithmetic reference model.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             enable;
    logic [WIDTH:0]   Diff;
    logic             busy;
    logic             valid;

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .enable (enable),
        .Diff   (Diff),
        .busy   (busy),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    // Reference: A - B in WIDTH+1-bit two's complement.
    function automatic logic [WIDTH:0] ref_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int r;
        r = int'(a) - int'(b);
        return (WIDTH+1)'(r);
    endfunction

    // Start one operation and observe it for a bounded window. k counts
    // rising edges after the start edge; samples are taken on the falling edge.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int busy_cyc, output int valids,
                          output logic [WIDTH:0] d);
        @(negedge clk);
        A = a; B = b; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
        lat = -1; busy_cyc = 0; valids = 0; d = 'x;
        for (int k = 0; k < 3 * LAT; k++) begin
            if (busy === 1'b1) busy_cyc++;
            if (valid === 1'b1) begin
                valids++;
                if (lat < 0) begin
                    lat = k;
                    d   = Diff;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int lat, bc, nv;
        logic [WIDTH:0] d, exp;
        exp = ref_diff(a, b);
        run_op(a, b, lat, bc, nv, d);
        tests++;
        if (d !== exp) begin
            fails++;
            $display("FAIL %s diff A=%0d B=%0d got %b expected %b", name, a, b, d, exp);
        end
        tests++;
        if (lat !== LAT) begin
            fails++;
            $display("FAIL %s latency got %0d expected %0d", name, lat, LAT);
        end
        tests++;
        if (bc !== WIDTH || nv !== 1) begin
            fails++;
            $display("FAIL %s busy/valid count got busy=%0d valid=%0d expected %0d/1", name, bc, nv, WIDTH);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; A = 4'd5; B = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (Diff !== '0 || busy !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_values got Diff=%b busy=%b valid=%b expected 0/0/0", Diff, busy, valid);
        end
        rst = 1'b0; enable = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_start got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic;
        check_op("basic_3_1", 4'd3, 4'd1);
        repeat (10) @(negedge clk);
        tests++;
        if (Diff !== 5'b00010) begin
            fails++;
            $display("FAIL basic_hold got %b expected 00010", Diff);
        end
    endtask

    task automatic test_negative;
        check_op("neg_1_2", 4'd1, 4'd2);
        check_op("equal_2_2", 4'd2, 4'd2);
    endtask

    task automatic test_extremes;
        check_op("max_15_0", 4'd15, 4'd0);
        check_op("min_0_15", 4'd0, 4'd15);
    endtask

    task automatic test_async_reset;
        // Diff is nonzero (10001) from the previous test; reset must clear it without a clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (Diff !== '0 || busy !== 1'b0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got Diff=%b busy=%b valid=%b expected 0/0/0", Diff, busy, valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_busy_interference;
        int nv;
        logic [WIDTH:0] d;
        @(negedge clk);
        A = 4'd2; B = 4'd1; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        A = 4'd9; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        nv = 0; d = 'x;
        for (int k = 0; k < 4 * LAT; k++) begin
            if (valid === 1'b1) begin
                nv++;
                d = Diff;
            end
            @(negedge clk);
        end
        tests++;
        if (d !== 5'b00001) begin
            fails++;
            $display("FAIL busy_interference diff got %b expected 00001", d);
        end
        tests++;
        if (nv !== 1) begin
            fails++;
            $display("FAIL busy_interference valid pulses got %0d expected 1", nv);
        end
    endtask

    task automatic test_reset_mid_op;
        int nv;
        @(negedge clk);
        A = 4'd7; B = 4'd3; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int k = 0; k < 3 * LAT; k++) begin
            if (valid === 1'b1 || busy === 1'b1) nv++;
            @(negedge clk);
        end
        tests++;
        if (nv !== 0 || Diff !== '0) begin
            fails++;
            $display("FAIL reset_mid_op got activity=%0d Diff=%b expected 0 and 00000", nv, Diff);
        end
        check_op("after_reset_7_3", 4'd7, 4'd3);
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] a1, b1, a2, b2;
        logic [WIDTH:0] d1, d2;
        int t1, t2, nv;
        a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
        a2 = WIDTH'($urandom); b2 = WIDTH'($urandom);
        @(negedge clk);
        A = a1; B = b1; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A = a2; B = b2;
        t1 = -1; t2 = -1; nv = 0; d1 = 'x; d2 = 'x;
        for (int k = 0; k < 4 * LAT; k++) begin
            // Next start lands on edge WIDTH+2; release enable right after it.
            if (k == WIDTH + 2) enable = 1'b0;
            if (valid === 1'b1) begin
                nv++;
                if (t1 < 0) begin t1 = k; d1 = Diff; end
                else if (t2 < 0) begin t2 = k; d2 = Diff; end
            end
            @(negedge clk);
        end
        enable = 1'b0;
        tests++;
        if (d1 !== ref_diff(a1, b1) || d2 !== ref_diff(a2, b2)) begin
            fails++;
            $display("FAIL back_to_back diffs got %b,%b expected %b,%b", d1, d2, ref_diff(a1, b1), ref_diff(a2, b2));
        end
        tests++;
        if (t1 !== LAT || t2 !== 2 * LAT + 1 || nv !== 2) begin
            fails++;
            $display("FAIL back_to_back timing got t1=%0d t2=%0d n=%0d expected %0d %0d 2", t1, t2, nv, LAT, 2 * LAT + 1);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            check_op("random", WIDTH'($urandom), WIDTH'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_extremes();
        test_async_reset();
        test_busy_interference();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
